// File: rtl/msi_cfg_ctrl_if.sv
// msi_cfg_ctrl_if
//   Request handshake between the bus-side register block and the MSI
//   configuration sequencer.
//   req_valid  master -> slave  word available on req_data
//   req_data   master -> slave  configuration word (DATA_W bits)
//   req_ready  slave -> master  sequencer idle and able to accept
interface msi_cfg_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic [DATA_W-1:0] req_data;
    logic              req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/msi_cfg_ctrl.sv
// msi_cfg_ctrl
//   Sequencer for the MSI serial configuration port. Takes one word per
//   valid/ready handshake and shifts it out MSB-first as an SPI mode-0 frame,
//   then holds chip select high for a minimum gap before accepting again.
// Ports
//   clk        system clock, rising edge
//   RSTn       synchronous active-low reset
//   req        request handshake (req_valid, req_data, req_ready), slave side
//   busy       frame or gap in progress
//   done       one-cycle pulse when a frame completes
//   MSI_CS     chip select, active-low
//   MSI_SCLK   serial clock, idle low
//   MSI_SDATA  serial data, MSB first
module msi_cfg_ctrl #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic                clk,
    input  logic                RSTn,
    msi_cfg_ctrl_if.slave       req,
    output logic                busy,
    output logic                done,
    output logic                MSI_CS,
    output logic                MSI_SCLK,
    output logic                MSI_SDATA
);
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W   = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;

    state_t              state;
    logic [CNT_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    // Bits still to send after the one currently on MSI_SDATA.
    logic [DATA_W-2:0]   shreg;
    logic                div_last;
    logic                gap_last;

    assign div_last      = (div_cnt == CNT_W'(CLK_DIV - 1));
    assign gap_last      = (div_cnt == CNT_W'(CS_GAP - 1));
    assign busy          = (state != IDLE);
    // Ready is gated by RSTn so it reads low throughout reset, even before
    // the first reset edge has returned the FSM to IDLE.
    assign req.req_ready = (state == IDLE) && RSTn;

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            MSI_CS    <= 1'b1;
            MSI_SCLK  <= 1'b0;
            MSI_SDATA <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req.req_valid) begin
                        shreg     <= req.req_data[DATA_W-2:0];
                        MSI_SDATA <= req.req_data[DATA_W-1];
                        MSI_CS    <= 1'b0;
                        bit_cnt   <= BIT_W'(DATA_W - 1);
                        div_cnt   <= '0;
                        state     <= LOW;
                    end
                end
                LOW: begin
                    if (div_last) begin
                        div_cnt  <= '0;
                        MSI_SCLK <= 1'b1;
                        state    <= HIGH;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (div_last) begin
                        div_cnt  <= '0;
                        MSI_SCLK <= 1'b0;
                        if (bit_cnt == '0) begin
                            state <= HOLD;
                        end else begin
                            // Data only moves on the falling SCLK edge.
                            bit_cnt   <= bit_cnt - 1'b1;
                            MSI_SDATA <= shreg[DATA_W-2];
                            shreg     <= shreg << 1;
                            state     <= LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (div_last) begin
                        div_cnt   <= '0;
                        MSI_CS    <= 1'b1;
                        MSI_SDATA <= 1'b0;
                        done      <= 1'b1;
                        state     <= GAP;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msi_cfg_ctrl.sv
module tb_msi_cfg_ctrl;
    logic clk = 1'b0;
    logic RSTn = 1'b0;
    always #5 clk = ~clk;

    msi_cfg_ctrl_if #(.DATA_W(16)) ifa ();
    msi_cfg_ctrl_if #(.DATA_W(16)) ifb ();

    logic busy_a, done_a, cs_a, sclk_a, sd_a;
    logic busy_b, done_b, cs_b, sclk_b, sd_b;

    msi_cfg_ctrl #(.DATA_W(16), .CLK_DIV(4), .CS_GAP(2)) dut_a (
        .clk(clk), .RSTn(RSTn), .req(ifa), .busy(busy_a), .done(done_a),
        .MSI_CS(cs_a), .MSI_SCLK(sclk_a), .MSI_SDATA(sd_a));

    msi_cfg_ctrl #(.DATA_W(16), .CLK_DIV(1), .CS_GAP(1)) dut_b (
        .clk(clk), .RSTn(RSTn), .req(ifb), .busy(busy_b), .done(done_b),
        .MSI_CS(cs_b), .MSI_SCLK(sclk_b), .MSI_SDATA(sd_b));

    int total = 0;
    int bad = 0;
    int cur = 0;

    logic m_cs, m_sclk, m_sd, m_ready, m_done, m_busy;
    assign m_cs    = (cur != 0) ? cs_b : cs_a;
    assign m_sclk  = (cur != 0) ? sclk_b : sclk_a;
    assign m_sd    = (cur != 0) ? sd_b : sd_a;
    assign m_ready = (cur != 0) ? ifb.req_ready : ifa.req_ready;
    assign m_done  = (cur != 0) ? done_b : done_a;
    assign m_busy  = (cur != 0) ? busy_b : busy_a;

    // Continuous protocol checks on both instances.
    logic [1:0] p_sclk = '0;
    logic [1:0] p_sd = '0;
    always begin
        @(negedge clk);
        #2;
        if (RSTn) begin
            total++;
            if (busy_a !== ~ifa.req_ready) begin
                bad++; $display("FAIL busy_ready_a: busy=%b ready=%b", busy_a, ifa.req_ready);
            end
            total++;
            if (busy_b !== ~ifb.req_ready) begin
                bad++; $display("FAIL busy_ready_b: busy=%b ready=%b", busy_b, ifb.req_ready);
            end
            if (p_sclk[0] && sclk_a) begin
                total++;
                if (sd_a !== p_sd[0]) begin
                    bad++; $display("FAIL sdata_stable_a: got %b want %b", sd_a, p_sd[0]);
                end
            end
            if (p_sclk[1] && sclk_b) begin
                total++;
                if (sd_b !== p_sd[1]) begin
                    bad++; $display("FAIL sdata_stable_b: got %b want %b", sd_b, p_sd[1]);
                end
            end
        end
        p_sclk = {sclk_b, sclk_a};
        p_sd   = {sd_b, sd_a};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int s, input logic v, input logic [15:0] d);
        if (s == 0) begin ifa.req_valid = v; ifa.req_data = d; end
        else begin ifb.req_valid = v; ifb.req_data = d; end
    endtask

    // Sends one word and checks the observed frame against the timing and
    // bit rules derived from CLK_DIV/CS_GAP. Called and returns at a negedge.
    task automatic do_frame(input int s, input logic [15:0] w, input bit keep,
                            input bit jitter, input bit expect_immediate);
        int d, g, waited, e, nbits, cs_low, lat, rise, ndone, done_e;
        int first_r, last_r, sd_chg, exp_chg;
        logic [15:0] got;
        logic psclk, pcs, psd, rise_sd;
        d = (s != 0) ? 1 : 4;
        g = (s != 0) ? 1 : 2;
        cur = s;
        waited = 0;
        while (!m_ready && waited < 400) begin @(negedge clk); waited++; end
        total++;
        if (!m_ready) begin
            bad++; $display("FAIL wait_ready: ready=%b after %0d cycles, want 1", m_ready, waited);
            return;
        end
        if (expect_immediate) begin
            total++;
            if (waited != 0) begin
                bad++; $display("FAIL b2b_accept: waited %0d cycles want 0", waited);
            end
        end
        set_req(s, 1'b1, w);
        @(posedge clk);
        @(negedge clk);
        if (!keep) set_req(s, 1'b0, 16'($urandom));
        got = '0; nbits = 0; cs_low = 0; lat = -1; rise = -1; ndone = 0; done_e = -1;
        first_r = -1; last_r = -1; sd_chg = 0; rise_sd = 1'bx;
        psclk = 1'b0; pcs = 1'b1; psd = 1'b0;
        for (int i = 1; i <= 600; i++) begin
            e = i - 1;
            if (!m_cs && m_sclk && !psclk) begin
                got = {got[14:0], m_sd}; nbits++;
                if (first_r < 0) first_r = e;
                last_r = e;
            end
            if (!m_cs) cs_low++;
            if (!m_cs && !pcs && m_sd !== psd) sd_chg++;
            if (m_cs && !pcs && rise < 0) begin rise = e; rise_sd = m_sd; end
            if (m_done) begin ndone++; done_e = e; end
            if (m_ready) begin lat = e; break; end
            if (jitter) set_req(s, 1'($urandom_range(0, 1)), 16'($urandom));
            psclk = m_sclk; pcs = m_cs; psd = m_sd;
            @(negedge clk);
        end
        if (!keep) set_req(s, 1'b0, 16'($urandom));
        exp_chg = $countones((w ^ (w >> 1)) & 16'h7FFF);
        total++;
        if (got !== w) begin bad++; $display("FAIL bits: got %h want %h", got, w); end
        total++;
        if (nbits != 16) begin bad++; $display("FAIL nbits: got %0d want 16", nbits); end
        total++;
        if (cs_low != 33 * d) begin bad++; $display("FAIL cs_low: got %0d want %0d", cs_low, 33 * d); end
        total++;
        if (rise != 33 * d) begin bad++; $display("FAIL cs_rise: got %0d want %0d", rise, 33 * d); end
        total++;
        if (lat != 33 * d + g) begin bad++; $display("FAIL ready_lat: got %0d want %0d", lat, 33 * d + g); end
        total++;
        if (lat - rise != g) begin bad++; $display("FAIL gap: got %0d want %0d", lat - rise, g); end
        total++;
        if (ndone != 1 || done_e != rise) begin
            bad++; $display("FAIL done: count %0d at %0d want 1 at %0d", ndone, done_e, rise);
        end
        total++;
        if (first_r != d || last_r - first_r != 30 * d) begin
            bad++; $display("FAIL sclk_timing: first %0d span %0d want %0d span %0d",
                            first_r, last_r - first_r, d, 30 * d);
        end
        total++;
        if (sd_chg != exp_chg) begin bad++; $display("FAIL sd_changes: got %0d want %0d", sd_chg, exp_chg); end
        total++;
        if (rise_sd !== 1'b0) begin bad++; $display("FAIL gap_sdata: got %b want 0", rise_sd); end
    endtask

    task automatic test_reset();
        int nr, guard;
        logic prev;
        cur = 0;
        RSTn = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({cs_a, sclk_a, sd_a, ifa.req_ready, done_a, busy_a} !== 6'b100000) begin
            bad++; $display("FAIL reset_state: cs,sclk,sd,rdy,done,busy=%b want 100000",
                            {cs_a, sclk_a, sd_a, ifa.req_ready, done_a, busy_a});
        end
        RSTn = 1'b1;
        @(negedge clk);
        total++;
        if (ifa.req_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got %b want 1", ifa.req_ready); end
        set_req(0, 1'b1, 16'hA5C3);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 16'h0000);
        nr = 0; guard = 0; prev = 1'b0;
        while (nr < 8 && guard < 300) begin
            if (sclk_a && !prev) nr++;
            prev = sclk_a;
            if (nr < 8) begin @(negedge clk); guard++; end
        end
        while (sclk_a && guard < 300) begin @(negedge clk); guard++; end
        total++;
        if (cs_a !== 1'b0 || sd_a !== 1'b1 || guard >= 300) begin
            bad++; $display("FAIL mid_frame_bit7: cs=%b sd=%b guard=%0d want cs=0 sd=1", cs_a, sd_a, guard);
        end
        RSTn = 1'b0;
        @(negedge clk);
        total++;
        if ({cs_a, sclk_a, sd_a, ifa.req_ready, done_a, busy_a} !== 6'b100000) begin
            bad++; $display("FAIL abort_state: cs,sclk,sd,rdy,done,busy=%b want 100000",
                            {cs_a, sclk_a, sd_a, ifa.req_ready, done_a, busy_a});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (done_a !== 1'b0 || cs_a !== 1'b1 || ifa.req_ready !== 1'b0) begin
                bad++; $display("FAIL reset_hold: done=%b cs=%b rdy=%b want 0 1 0", done_a, cs_a, ifa.req_ready);
            end
        end
        RSTn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (done_a !== 1'b0 || ifa.req_ready !== 1'b1 || cs_a !== 1'b1) begin
                bad++; $display("FAIL post_release: done=%b rdy=%b cs=%b want 0 1 1", done_a, ifa.req_ready, cs_a);
            end
        end
    endtask

    task automatic test_single();
        do_frame(0, 16'hA5C3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_frame(0, 16'h0001, 1'b1, 1'b0, 1'b0);
        do_frame(0, 16'h8000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_edge_words();
        do_frame(1, 16'h0000, 1'b0, 1'b0, 1'b0);
        do_frame(1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stability();
        do_frame(0, 16'h1234, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) begin
            do_frame(0, 16'($urandom), 1'b0, 1'b0, 1'b0);
            do_frame(1, 16'($urandom), 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        set_req(0, 1'b0, 16'h0000);
        set_req(1, 1'b0, 16'h0000);
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_edge_words();
        test_stability();
        test_random();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
